pipe_adder: RTL and testbench
=============================

# pipe_adder

Parametrised, pipelined ripple-carry adder with valid/ready handshake on both sides. It splits a WIDTH-bit add (a + b + c) into WIDTH/SEG segments, resolving one SEG-bit segment per pipeline stage with the carry registered between stages. It is the clocked, multi-bit successor to the gate-level adder cells and is used wherever wide adds must close timing at full clock rate with backpressure from downstream.

## Interface
- WIDTH, 16: operand and sum width in bits; must be ≥ 1.
- SEG, 4: bits resolved per stage. WIDTH must be an integer multiple of SEG. NSTG = WIDTH/SEG stages.
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  a, b, c valid this cycle
- in_ready  out  1  block accepts input this cycle
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- c  in  1  carry-in
- out_valid  out  1  sum, carry, overflow valid
- out_ready  in  1  downstream accepts output this cycle
- sum  out  WIDTH  (a + b + c) mod 2^WIDTH
- carry  out  1  unsigned carry-out, bit WIDTH of a + b + c
- overflow  out  1  two's-complement overflow: carry into MSB XOR carry out of MSB

Clock is clk; reset is rst_n, asynchronous and active-low.

## Operation
- Pipeline has NSTG stage registers S1..SNSTG. Each holds a valid bit, the resolved low sum bits, the inter-stage carry, and the unresolved upper bits of a and b.
- S1 loads segment 0: a[SEG-1:0] + b[SEG-1:0] + c.
- Sk (k ≥ 2) loads segment k-1 from S(k-1): it adds the operand slice and S(k-1)'s carry, and appends the result above the already-resolved bits.
- SNSTG is the output register. sum, carry, overflow and out_valid come directly from it, with no combinational path from inputs.
- overflow is computed in the final segment from the carry into bit WIDTH-1 and the carry out of bit WIDTH-1.
- Global advance: adv = !out_valid | out_ready. in_ready = adv.
- When adv=1, every stage loads from its predecessor and valid bits shift with the data. S1.valid loads in_valid & in_ready.
- When adv=0, all stages hold, including their valid bits. Bubbles are not collapsed.
- A transfer occurs on an edge where in_valid & in_ready, or out_valid & out_ready.
- Stages whose valid bit is 0 may hold don't-care data. Outputs other than out_valid are only meaningful while out_valid=1.
- SEG = WIDTH gives a single-stage registered adder (NSTG = 1).
- in_ready depends combinationally on out_ready and out_valid only, never on in_valid.

## Timing
- Reset (rst_n low, asynchronous): all stage valid bits clear, out_valid=0, sum=0, carry=0, overflow=0.
- in_ready=1 while rst_n is low and in the first cycle after release.
- Reset asserted mid-operation discards all in-flight operations. Nothing is emitted after release until new inputs are accepted.
- Latency: an operation accepted in cycle n appears with out_valid=1 in cycle n+NSTG, provided adv=1 in cycles n+1..n+NSTG-1.
- Each cycle with adv=0 adds one cycle of latency.
- Throughput: one operation per cycle while out_ready=1.
- Stall: while out_valid=1 and out_ready=0, sum, carry and overflow are held stable and in_ready=0.
- Simultaneous output pop and input push in the same cycle are both taken.
- Order is preserved. No operation is dropped or duplicated across any stall pattern.
- Pipeline capacity is exactly NSTG operations.

## Test plan
(WIDTH=16, SEG=4, NSTG=4 unless stated.)
- Reset check: hold rst_n=0 for 3 cycles, then release. Required: out_valid=0, sum=0, carry=0, overflow=0, in_ready=1.
- Single op, a=16'h1234, b=16'h4321, c=0, accepted in cycle n. Required: out_valid in cycle n+4 with sum=16'h5555, carry=0, overflow=0.
- Full carry ripple, a=16'hFFFF, b=16'h0000, c=1. Required: sum=16'h0000, carry=1, overflow=0.
- Signed overflow, a=16'h7FFF, b=16'h0001, c=0. Required: sum=16'h8000, carry=0, overflow=1.
- Streaming with backpressure: push 20 random operations back-to-back while out_ready toggles in a random pattern (≈50%). Required: all 20 results in order and equal to the reference model; outputs stable during every stall; no input accepted while in_ready=0.
- Mid-flight reset: push 3 operations, pulse rst_n low for 1 cycle, then push a=16'h0001, b=16'h0001. Required: only one result, sum=16'h0002, out_valid 4 cycles after its accept. Repeat the single-op and full-ripple cases with WIDTH=8, SEG=8 and check 1-cycle latency.

Source files
------------

// File: rtl/pipe_adder.sv
// pipe_adder: pipelined segmented ripple-carry adder with valid/ready.
// One SEG-bit segment is resolved per stage; the carry is registered between stages.
module pipe_adder #(
    parameter int WIDTH = 16,
    parameter int SEG   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             overflow
);
    localparam int NSTG = WIDTH / SEG;
    localparam int LAST = NSTG - 1;

    logic             adv;
    logic [NSTG-1:0]  vld_q;
    logic [NSTG-1:0]  vld_d;
    logic [NSTG-1:0]  cy_q;
    logic [NSTG-1:0]  cy_d;
    logic [WIDTH-1:0] sum_q [NSTG];
    logic [WIDTH-1:0] sum_d [NSTG];
    logic [WIDTH-1:0] a_q   [NSTG];
    logic [WIDTH-1:0] b_q   [NSTG];
    logic [WIDTH-1:0] src_a [NSTG];
    logic [WIDTH-1:0] src_b [NSTG];
    logic [WIDTH-1:0] src_s [NSTG];
    logic [NSTG-1:0]  src_c;
    logic             ov_q;
    logic             ov_d;

    assign adv       = !vld_q[LAST] | out_ready;
    assign in_ready  = adv;
    assign out_valid = vld_q[LAST];
    assign sum       = sum_q[LAST];
    assign carry     = cy_q[LAST];
    assign overflow  = ov_q;

    for (genvar k = 0; k < NSTG; k++) begin : g_stg
        logic [SEG:0] seg;

        if (k == 0) begin : g_head
            assign src_a[k] = a;
            assign src_b[k] = b;
            assign src_s[k] = '0;
            assign src_c[k] = c;
            assign vld_d[k] = in_valid & adv;
        end else begin : g_body
            assign src_a[k] = a_q[k-1];
            assign src_b[k] = b_q[k-1];
            assign src_s[k] = sum_q[k-1];
            assign src_c[k] = cy_q[k-1];
            assign vld_d[k] = vld_q[k-1];
        end

        assign seg = {1'b0, src_a[k][k*SEG +: SEG]}
                   + {1'b0, src_b[k][k*SEG +: SEG]}
                   + (SEG+1)'(src_c[k]);

        // Splice the new segment in above the bits already resolved upstream
        assign sum_d[k] = (src_s[k] & ~(WIDTH'({SEG{1'b1}}) << (k*SEG)))
                        | (WIDTH'(seg[SEG-1:0]) << (k*SEG));
        assign cy_d[k]  = seg[SEG];
    end

    // Carry into the MSB is recovered as a ^ b ^ sum at that bit
    assign ov_d = src_a[LAST][WIDTH-1] ^ src_b[LAST][WIDTH-1]
                ^ sum_d[LAST][WIDTH-1] ^ cy_d[LAST];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            cy_q  <= '0;
            ov_q  <= 1'b0;
            for (int i = 0; i < NSTG; i++) begin
                sum_q[i] <= '0;
                a_q[i]   <= '0;
                b_q[i]   <= '0;
            end
        end else if (adv) begin
            vld_q <= vld_d;
            cy_q  <= cy_d;
            ov_q  <= ov_d;
            for (int i = 0; i < NSTG; i++) begin
                sum_q[i] <= sum_d[i];
                a_q[i]   <= src_a[i];
                b_q[i]   <= src_b[i];
            end
        end
    end

endmodule

// File: tb/tb_pipe_adder.sv
// tb_pipe_adder: randomized and directed checks of pipe_adder against a
// queue-based arithmetic model, for a 16/4 pipeline and an 8/8 single stage.
module tb_pipe_adder;

    typedef struct {
        logic [15:0] s;
        logic        cy;
        logic        ov;
        int          acc;
        int          stl;
        bit          shown;
    } exp_t;

    logic clk;
    logic rst_n;

    logic        in_valid0, in_ready0, c0, out_valid0, out_ready0;
    logic [15:0] a0, b0, sum0;
    logic        carry0, overflow0;

    logic        in_valid1, in_ready1, c1, out_valid1, out_ready1;
    logic [7:0]  a1, b1, sum1;
    logic        carry1, overflow1;

    int   ncmp, nerr, cyc;
    exp_t eq [2][64];
    int   hd [2];
    int   tl [2];
    int   stalls [2];
    bit   pst [2];
    logic [15:0] ps [2];
    logic pcy [2];
    logic pof [2];
    bit   rnd_en;

    pipe_adder #(.WIDTH(16), .SEG(4)) u0 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid0), .in_ready(in_ready0),
        .a(a0), .b(b0), .c(c0),
        .out_valid(out_valid0), .out_ready(out_ready0),
        .sum(sum0), .carry(carry0), .overflow(overflow0)
    );

    pipe_adder #(.WIDTH(8), .SEG(8)) u1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid1), .in_ready(in_ready1),
        .a(a1), .b(b1), .c(c1),
        .out_valid(out_valid1), .out_ready(out_ready1),
        .sum(sum1), .carry(carry1), .overflow(overflow1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    function automatic exp_t model(input logic [15:0] a, input logic [15:0] b,
                                   input logic c, input int w);
        exp_t r;
        int   m, t, sa, sb, ss;
        m  = (1 << w) - 1;
        t  = (int'(a) & m) + (int'(b) & m) + int'(c);
        sa = (int'(a) >> (w - 1)) & 1;
        sb = (int'(b) >> (w - 1)) & 1;
        ss = ((t & m) >> (w - 1)) & 1;
        r.s     = 16'(t & m);
        r.cy    = ((t >> w) & 1) == 1;
        r.ov    = (sa == sb) && (ss != sa);
        r.acc   = 0;
        r.stl   = 0;
        r.shown = 1'b0;
        return r;
    endfunction

    task automatic mon(input int id, input int ns, input int w,
                       input logic iv, input logic ir,
                       input logic [15:0] a, input logic [15:0] b,
                       input logic c, input logic ovl, input logic ordy,
                       input logic [15:0] s, input logic cy, input logic of);
        exp_t e;
        int   lat;
        chk($sformatf("in_ready_rule%0d", id), 32'(ir), 32'(!ovl | ordy));
        if (pst[id]) begin
            chk($sformatf("stall_valid%0d", id), 32'(ovl), 32'd1);
            chk($sformatf("stall_sum%0d", id), 32'(s), 32'(ps[id]));
            chk($sformatf("stall_carry%0d", id), 32'(cy), 32'(pcy[id]));
            chk($sformatf("stall_ovf%0d", id), 32'(of), 32'(pof[id]));
        end
        if (ovl) begin
            ncmp++;
            if (hd[id] == tl[id]) begin
                nerr++;
                $display("FAIL out_unexpected%0d: got out_valid=1 sum=%0h expected no output (cycle %0d)",
                         id, s, cyc);
            end else begin
                ncmp--;
                e = eq[id][hd[id] % 64];
                chk($sformatf("sum%0d", id), 32'(s), 32'(e.s));
                chk($sformatf("carry%0d", id), 32'(cy), 32'(e.cy));
                chk($sformatf("ovf%0d", id), 32'(of), 32'(e.ov));
                if (!e.shown) begin
                    lat = ns + (stalls[id] - e.stl);
                    chk($sformatf("latency%0d", id), 32'(cyc - e.acc), 32'(lat));
                    eq[id][hd[id] % 64].shown = 1'b1;
                end
                if (ordy) hd[id]++;
            end
        end
        if (iv && ir) begin
            e = model(a, b, c, w);
            e.acc = cyc;
            e.stl = stalls[id];
            eq[id][tl[id] % 64] = e;
            tl[id]++;
        end
        if (!(!ovl | ordy)) stalls[id]++;
        pst[id] = ovl & !ordy;
        ps[id]  = s;
        pcy[id] = cy;
        pof[id] = of;
    endtask

    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            chk("rst_valid0", 32'(out_valid0), 32'd0);
            chk("rst_sum0", 32'(sum0), 32'd0);
            chk("rst_carry0", 32'(carry0), 32'd0);
            chk("rst_ovf0", 32'(overflow0), 32'd0);
            chk("rst_ready0", 32'(in_ready0), 32'd1);
            chk("rst_valid1", 32'(out_valid1), 32'd0);
            chk("rst_ready1", 32'(in_ready1), 32'd1);
            for (int i = 0; i < 2; i++) begin
                hd[i]  = tl[i];
                pst[i] = 1'b0;
            end
        end else begin
            mon(0, 4, 16, in_valid0, in_ready0, a0, b0, c0,
                out_valid0, out_ready0, sum0, carry0, overflow0);
            mon(1, 1, 8, in_valid1, in_ready1, {8'h00, a1}, {8'h00, b1}, c1,
                out_valid1, out_ready1, {8'h00, sum1}, carry1, overflow1);
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            out_ready0 = rnd_en ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    task automatic push(input int id, input logic [15:0] a,
                        input logic [15:0] b, input logic c);
        int  n;
        logic rdy;
        n = 0;
        if (id == 0) begin
            in_valid0 = 1'b1; a0 = a; b0 = b; c0 = c;
        end else begin
            in_valid1 = 1'b1; a1 = a[7:0]; b1 = b[7:0]; c1 = c;
        end
        do begin
            @(negedge clk);
            n++;
            rdy = (id == 0) ? in_ready0 : in_ready1;
        end while (!rdy && n < 200);
        if (!rdy) begin
            ncmp++;
            nerr++;
            $display("FAIL push_timeout%0d: in_ready stayed 0 for %0d cycles, required 1", id, n);
        end
        @(posedge clk);
        #1;
        in_valid0 = 1'b0;
        in_valid1 = 1'b0;
    endtask

    task automatic wait_out(input int id, input logic [15:0] es,
                            input logic ecy, input logic eov, input int elat);
        int   n;
        logic v;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            v = (id == 0) ? out_valid0 : out_valid1;
        end while (!v && n < 20);
        chk($sformatf("dir_valid%0d", id), 32'(v), 32'd1);
        chk($sformatf("dir_latency%0d", id), 32'(n), 32'(elat));
        if (id == 0) begin
            chk("dir_sum0", 32'(sum0), 32'(es));
            chk("dir_carry0", 32'(carry0), 32'(ecy));
            chk("dir_ovf0", 32'(overflow0), 32'(eov));
        end else begin
            chk("dir_sum1", 32'(sum1), 32'(es[7:0]));
            chk("dir_carry1", 32'(carry1), 32'(ecy));
            chk("dir_ovf1", 32'(overflow1), 32'(eov));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int id);
        int n;
        n = 0;
        while (hd[id] != tl[id] && n < 500) begin
            @(posedge clk);
            n++;
        end
        chk($sformatf("drain%0d", id), 32'(tl[id] - hd[id]), 32'd0);
    endtask

    initial begin
        exp_t m;
        ncmp = 0; nerr = 0; cyc = 0;
        rnd_en = 1'b0;
        for (int i = 0; i < 2; i++) begin
            hd[i] = 0; tl[i] = 0; stalls[i] = 0; pst[i] = 1'b0;
            ps[i] = '0; pcy[i] = 1'b0; pof[i] = 1'b0;
        end
        in_valid0 = 1'b0; a0 = '0; b0 = '0; c0 = 1'b0; out_ready0 = 1'b1;
        in_valid1 = 1'b0; a1 = '0; b1 = '0; c1 = 1'b0; out_ready1 = 1'b1;

        m = model(16'h1234, 16'h4321, 1'b0, 16);
        chk("model_add", 32'({m.cy, m.ov, m.s}), 32'h05555);
        m = model(16'hFFFF, 16'h0000, 1'b1, 16);
        chk("model_ripple", 32'({m.cy, m.ov, m.s}), 32'h20000);
        m = model(16'h7FFF, 16'h0001, 1'b0, 16);
        chk("model_ovf", 32'({m.cy, m.ov, m.s}), 32'h18000);
        m = model(16'h0080, 16'h0080, 1'b0, 8);
        chk("model_w8", 32'({m.cy, m.ov, m.s}), 32'h30000);

        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_ready0", 32'(in_ready0), 32'd1);
        chk("post_rst_valid0", 32'(out_valid0), 32'd0);
        @(posedge clk);
        #1;

        push(0, 16'h1234, 16'h4321, 1'b0);
        wait_out(0, 16'h5555, 1'b0, 1'b0, 4);
        push(0, 16'hFFFF, 16'h0000, 1'b1);
        wait_out(0, 16'h0000, 1'b1, 1'b0, 4);
        push(0, 16'h7FFF, 16'h0001, 1'b0);
        wait_out(0, 16'h8000, 1'b0, 1'b1, 4);
        drain(0);

        rnd_en = 1'b1;
        for (int i = 0; i < 20; i++)
            push(0, 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
        drain(0);
        rnd_en = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 3; i++)
            push(0, 16'($urandom), 16'($urandom), 1'b0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        push(0, 16'h0001, 16'h0001, 1'b0);
        wait_out(0, 16'h0002, 1'b0, 1'b0, 4);
        repeat (10) @(posedge clk);
        #1;
        drain(0);

        push(1, 16'h0034, 16'h0021, 1'b0);
        wait_out(1, 16'h0055, 1'b0, 1'b0, 1);
        push(1, 16'h00FF, 16'h0000, 1'b1);
        wait_out(1, 16'h0000, 1'b1, 1'b0, 1);
        for (int i = 0; i < 8; i++)
            push(1, 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
        drain(1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
